// File: rtl/camera_sdram_writer_pkg.sv
// Shared constants and types for the camera-to-SDRAM frame writer.
package camera_sdram_writer_pkg;

  localparam int unsigned SDRAM_ADDR_W    = 24;
  localparam int unsigned PIX_W           = 16;
  localparam int unsigned FIFO_CNT_W      = 10;
  localparam int unsigned H_ACTIVE        = 640;
  localparam int unsigned V_ACTIVE        = 480;
  localparam int unsigned FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE;
  localparam int unsigned BURST_LEN_DEF   = 512;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_XFER      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } wr_state_e;

endpackage

// File: rtl/camera_sdram_writer_frame_addr_counter.sv
// Frame-buffer burst address: steps by one burst per commit and wraps to the
// base at the end of each frame, pulsing o_frame_done on the wrap.
module frame_addr_counter
  import camera_sdram_writer_pkg::*;
#(
  parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned STEP        = BURST_LEN_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_frame_done
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(BASE_ADDR + FRAME_WORDS);
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_addr;
  logic              r_frame_done;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_wrap;

  always_comb begin
    w_addr_nxt = r_addr + STEP_A;
    w_wrap     = (w_addr_nxt == END_A);
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= BASE_A;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= i_step && w_wrap;
      if (i_step) r_addr <= w_wrap ? BASE_A : w_addr_nxt;
    end
  end

  assign o_addr       = r_addr;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/camera_sdram_writer.sv
// Drains camera FIFO pixels into SDRAM as fixed-length write bursts at
// consecutive frame-buffer addresses.
module camera_sdram_writer
  import camera_sdram_writer_pkg::*;
#(
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned ADDR_W      = SDRAM_ADDR_W,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                  clk_100,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [FIFO_CNT_W-1:0] i_fifo_data_count,
  output logic                  o_fifo_rd_en,
  input  logic [PIX_W-1:0]      i_fifo_dout,
  output logic                  o_sdram_wr_req,
  output logic [ADDR_W-1:0]     o_sdram_wr_addr,
  input  logic                  i_sdram_wr_ack,
  input  logic                  i_sdram_wr_data_req,
  output logic [PIX_W-1:0]      o_sdram_wr_data,
  input  logic                  i_sdram_wr_done,
  output logic                  o_frame_done,
  output logic                  o_overrun_err
);

  localparam int unsigned WCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned CNT_CMP_W = FIFO_CNT_W + 1;
  localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(BURST_LEN - 1);
  localparam logic [CNT_CMP_W-1:0] BURST_THR = CNT_CMP_W'(BURST_LEN);

  wr_state_e         r_state;
  wr_state_e         w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_wr_req;
  logic              r_overrun;
  logic              w_rd;
  logic              w_spurious;
  logic              w_step;
  logic              w_start;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A full burst must already be buffered, so XFER never has to check for empty.
  assign w_start = i_enable && ({1'b0, i_fifo_data_count} >= BURST_THR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_start)                                    w_state_nxt = ST_REQ;
      ST_REQ:       if (i_sdram_wr_ack)                             w_state_nxt = ST_XFER;
      ST_XFER:      if (i_sdram_wr_data_req && r_wcnt == WCNT_LAST) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_sdram_wr_done)                            w_state_nxt = ST_IDLE;
      default:                                                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd       = 1'b0;
    w_spurious = 1'b0;
    w_step     = 1'b0;
    if (r_state == ST_XFER) w_rd       = i_sdram_wr_data_req;
    else                    w_spurious = i_sdram_wr_data_req;
    if (r_state == ST_WAIT_DONE) w_step = i_sdram_wr_done;
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_req  <= 1'b0;
      r_wcnt    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wr_req <= (w_state_nxt == ST_REQ);
      if (w_rd) r_wcnt <= (r_wcnt == WCNT_LAST) ? '0 : r_wcnt + WCNT_W'(1);
      if (w_spurious) r_overrun <= 1'b1;
    end
  end

  frame_addr_counter #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .STEP       (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_addr (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .i_step      (w_step),
    .o_addr      (o_sdram_wr_addr),
    .o_frame_done(o_frame_done)
  );

  assign o_fifo_rd_en    = w_rd;
  assign o_sdram_wr_data = i_fifo_dout;
  assign o_sdram_wr_req  = r_wr_req;
  assign o_overrun_err   = r_overrun;

endmodule

// File: doc/camera_sdram_writer.md
# camera_sdram_writer

Drains RGB565 pixels from the camera capture FIFO and writes them to SDRAM as fixed-length bursts at consecutive frame-buffer addresses. Sits directly downstream of the camera interface's 1024x16 FIFO and upstream of the SDRAM controller's write port. Addresses wrap at the end of each frame, and a pulse marks every completed frame.

## Interface
- BURST_LEN, 512, words per SDRAM write burst; must be ≤512 and a power of two.
- ADDR_W, 24, SDRAM word-address width.
- BASE_ADDR, 0, first word address of the frame buffer.
- FRAME_WORDS, 307200, words per frame (640x480); must be an integer multiple of BURST_LEN.
- clk_100  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  allows new bursts to start.
- fifo_data_count  in  10  word count of the camera FIFO.
- fifo_rd_en  out  1  camera FIFO read strobe.
- fifo_dout  in  16  camera FIFO data, valid the cycle after fifo_rd_en.
- sdram_wr_req  out  1  burst write request.
- sdram_wr_addr  out  ADDR_W  burst start address; held stable while sdram_wr_req is high.
- sdram_wr_ack  in  1  one-cycle pulse: the controller accepted the request.
- sdram_wr_data_req  in  1  controller pulls one word; the data is due the next cycle.
- sdram_wr_data  out  16  write data, equal to fifo_dout.
- sdram_wr_done  in  1  one-cycle pulse: the burst was committed.
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes.
- overrun_err  out  1  sticky flag: a data request arrived outside the transfer window.

## Operation
- FSM states are IDLE, REQ, XFER and WAIT_DONE.
- IDLE → REQ:
  - Taken when enable=1 and fifo_data_count ≥ BURST_LEN.
  - The required data is therefore already in the FIFO, so no FIFO empty check is needed during XFER.
- REQ:
  - sdram_wr_req=1 and sdram_wr_addr=addr_q.
  - On sdram_wr_ack: sdram_wr_req drops and the FSM goes to XFER.
- XFER:
  - fifo_rd_en = sdram_wr_data_req, combinational.
  - sdram_wr_data = fifo_dout, combinational passthrough.
  - The word counter wcnt increments on each data request.
  - On the request with wcnt == BURST_LEN-1: wcnt clears and the FSM goes to WAIT_DONE.
- WAIT_DONE:
  - On sdram_wr_done, addr_q advances by BURST_LEN.
  - If the new address equals BASE_ADDR+FRAME_WORDS, addr_q loads BASE_ADDR and frame_done pulses.
  - The FSM then returns to IDLE.
- sdram_wr_data_req is ignored in IDLE, REQ and WAIT_DONE: fifo_rd_en stays 0 and overrun_err sets. overrun_err clears only on reset.
- Deasserting enable mid-burst has no effect on the current burst. It only blocks the next IDLE → REQ transition.
- sdram_wr_ack outside REQ and sdram_wr_done outside WAIT_DONE are ignored.
- Width rules:
  - wcnt is log2(BURST_LEN) bits.
  - Address arithmetic is ADDR_W bits unsigned; it never overflows, because the frame wrap happens first.

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE, addr_q = BASE_ADDR, wcnt = 0.
  - sdram_wr_req = 0, fifo_rd_en = 0, frame_done = 0, overrun_err = 0.
- Reset mid-burst abandons the burst; the SDRAM controller is reset by the same rst_n.
- IDLE → sdram_wr_req high takes 1 cycle after the start condition becomes true.
- After sdram_wr_ack, data requests are accepted starting the next cycle.
- Data latency: data_req in cycle N → fifo_rd_en in cycle N → sdram_wr_data valid in cycle N+1.
- Back-to-back data requests give 1 word per cycle with no bubbles.
- frame_done asserts in the cycle after the final sdram_wr_done and lasts exactly 1 cycle.
- Minimum dead time between bursts: done → IDLE → REQ = 2 cycles.

## Structure
- Shared package constants:
  - FSM state encoding.
  - SDRAM ADDR_W.
  - Frame geometry (640, 480, FRAME_WORDS).
  - Default BURST_LEN.
- One natural sub-module: frame_addr_counter (base address, step, wrap, frame_done pulse). The FSM stays in the top module.

## Test plan
- Reset, then FIFO count 600, enable=1, controller acks immediately and streams 512 requests → sdram_wr_addr=0, 512 words equal to the FIFO sequence 0..511 in order, each one cycle after its request; no frame_done.
- FIFO count 511, enable=1 → no sdram_wr_req. Count rises to 512 → sdram_wr_req asserts within 1 cycle.
- Run 600 complete bursts → addresses 0, 512, …, 306688; a single 1-cycle frame_done after burst 600; burst 601 address = 0.
- Controller inserts gaps in sdram_wr_data_req (1 on, 3 off) → exactly 512 FIFO reads, no data skipped or duplicated.
- Drive sdram_wr_data_req in IDLE and during WAIT_DONE → fifo_rd_en stays 0 and overrun_err sets and stays 1 until rst_n.
- Assert rst_n low after word 200 of a burst → all outputs take their reset values immediately; after release, the first request is at address BASE_ADDR.
